// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and the bit-period divisor,
// computed once here so transmitter and receiver agree on the same rounding.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_tx_state_t;

  // Clock cycles per bit, rounded to nearest.
  function automatic int uart_div(input int clk_freq, input int baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered read data and registered full/empty/count flags.
// Pushes while full and pops while empty are ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr,
  input  logic [WIDTH-1:0]         din,
  input  logic                     rd,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_ONE     = (AW+1)'(1);
  localparam logic [AW:0] CNT_FULL_M1 = (AW+1)'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             push;
  logic             pop;

  assign push = wr && !full;
  assign pop  = rd && !empty;

  // NOTE: storage has no reset; the pointers alone decide what is valid, and
  // leaving the array unreset lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= din;
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      dout  <= '0;
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop) begin
        rptr <= rptr + 1'b1;
        dout <= mem[rptr];
      end
      unique case ({push, pop})
        2'b10: begin
          count <= count + 1'b1;
          full  <= (count == CNT_FULL_M1);
          empty <= 1'b0;
        end
        2'b01: begin
          count <= count - 1'b1;
          full  <= 1'b0;
          empty <= (count == CNT_ONE);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx.sv
// Buffered 8N1 UART transmitter: bytes queue in a FIFO and are shifted out LSB
// first with one start and one stop bit. Back-to-back frames have no idle gap.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200,
  parameter int DEPTH    = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             din,
  input  logic                   wr,
  output logic                   tx,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   busy,
  output logic                   overflow
);

  localparam int DIV = uart_div(CLK_FREQ, BAUD);
  localparam int BW  = $clog2(DIV);
  localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);

  uart_tx_state_t state, state_d;
  logic [BW-1:0]  baud_cnt, baud_cnt_d;
  logic [2:0]     bit_idx, bit_idx_d;
  logic [7:0]     shift, shift_d;
  logic [7:0]     fifo_dout;
  logic           rd;
  logic           tx_d;
  logic           bit_end;

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .wr    (wr),
    .din   (din),
    .rd    (rd),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  // NOTE: every output of this block gets a default first so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state;
    baud_cnt_d = baud_cnt + 1'b1;
    bit_idx_d  = bit_idx;
    shift_d    = shift;
    rd         = 1'b0;
    bit_end    = (baud_cnt == BAUD_LAST);
    unique case (state)
      IDLE: begin
        baud_cnt_d = '0;
        if (!empty) begin
          rd      = 1'b1;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          baud_cnt_d = '0;
          bit_idx_d  = '0;
          // Popped byte arrives on the registered FIFO read one cycle after the pop.
          shift_d    = fifo_dout;
          state_d    = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_cnt_d = '0;
          shift_d    = {1'b0, shift[7:1]};
          if (bit_idx == 3'd7) state_d = STOP;
          else                 bit_idx_d = bit_idx + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_cnt_d = '0;
          if (!empty) begin
            rd      = 1'b1;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // tx is registered from the next state so it lines up with the state register.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
      overflow <= 1'b0;
    end else begin
      state    <= state_d;
      baud_cnt <= baud_cnt_d;
      bit_idx  <= bit_idx_d;
      shift    <= shift_d;
      tx       <= tx_d;
      if (wr && full) overflow <= 1'b1;
    end
  end

  assign busy = (state != IDLE) || !empty;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: a default-rate instance (DIV=434) and a fast
// instance (DIV=3), both compared every cycle against a frame-position model.
module tb_uart_tx;

  localparam int DEPTH = 16;

  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_b, wr_b, tx_b, full_b, empty_b, busy_b, ovf_b;
  logic [7:0] din_b;
  logic [4:0] count_b;
  logic       reset_s, wr_s, tx_s, full_s, empty_s, busy_s, ovf_s;
  logic [7:0] din_s;
  logic [4:0] count_s;

  uart_tx u_big (
    .clk(clk), .reset(reset_b), .din(din_b), .wr(wr_b), .tx(tx_b), .full(full_b),
    .empty(empty_b), .count(count_b), .busy(busy_b), .overflow(ovf_b)
  );

  uart_tx #(.CLK_FREQ(1_000_000), .BAUD(300_000), .DEPTH(DEPTH)) u_small (
    .clk(clk), .reset(reset_s), .din(din_s), .wr(wr_s), .tx(tx_s), .full(full_s),
    .empty(empty_s), .count(count_s), .busy(busy_s), .overflow(ovf_s)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  bit sel   = 1'b0;

  // Reference model: queued bytes plus position inside the current 10*DIV-cycle frame.
  logic [7:0] m_q[$];
  logic [7:0] m_cur;
  int         m_pos;
  int         m_div;
  bit         m_ovf;

  logic       o_tx, o_full, o_empty, o_busy, o_ovf;
  logic [4:0] o_count;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d sel=%0d got=%0h exp=%0h", tag, cyc, sel, got, exp);
    end
  endtask

  function automatic logic model_tx();
    int k;
    if (m_pos < 0) return 1'b1;
    k = m_pos / m_div;
    if (k == 0) return 1'b0;
    if (k <= 8) return m_cur[k-1];
    return 1'b1;
  endfunction

  task automatic model_step(input logic w, input logic [7:0] d, input logic r);
    int  frame_len;
    bit  was_full;
    bit  do_pop;
    frame_len = 10 * m_div;
    if (r) begin
      m_q.delete();
      m_pos = -1;
      m_ovf = 1'b0;
      return;
    end
    was_full = (m_q.size() == DEPTH);
    do_pop   = (m_q.size() != 0) && (m_pos < 0 || m_pos == frame_len - 1);
    if (do_pop) begin
      m_cur = m_q.pop_front();
      m_pos = 0;
    end else if (m_pos == frame_len - 1) begin
      m_pos = -1;
    end else if (m_pos >= 0) begin
      m_pos++;
    end
    if (w) begin
      if (was_full) m_ovf = 1'b1;
      else          m_q.push_back(d);
    end
  endtask

  // One clock cycle: sample and compare this cycle's outputs, then drive the
  // inputs that the closing edge will sample and advance the model.
  task automatic cycle(input logic w, input logic [7:0] d, input logic r);
    @(negedge clk);
    o_tx    = sel ? tx_s    : tx_b;
    o_full  = sel ? full_s  : full_b;
    o_empty = sel ? empty_s : empty_b;
    o_busy  = sel ? busy_s  : busy_b;
    o_ovf   = sel ? ovf_s   : ovf_b;
    o_count = sel ? count_s : count_b;
    check("tx",       32'(o_tx),    32'(model_tx()));
    check("count",    32'(o_count), m_q.size());
    check("full",     32'(o_full),  32'(m_q.size() == DEPTH));
    check("empty",    32'(o_empty), 32'(m_q.size() == 0));
    check("busy",     32'(o_busy),  32'(m_pos >= 0 || m_q.size() != 0));
    check("overflow", 32'(o_ovf),   32'(m_ovf));
    if (sel) begin
      reset_s = r; wr_s = w; din_s = d;
      reset_b = 1'b1; wr_b = 1'b0; din_b = '0;
    end else begin
      reset_b = r; wr_b = w; din_b = d;
      reset_s = 1'b1; wr_s = 1'b0; din_s = '0;
    end
    model_step(w, d, r);
  endtask

  initial begin
    int p;
    reset_b = 1'b1; wr_b = 1'b0; din_b = '0;
    reset_s = 1'b1; wr_s = 1'b0; din_s = '0;
    m_div = 434;
    model_step(1'b0, 8'h00, 1'b1);
    repeat (3) @(posedge clk);

    // Reset state at default rate.
    cyc = -1;
    cycle(1'b0, 8'h00, 1'b1);
    check("rst_tx", 32'(o_tx), 1);
    check("rst_full", 32'(o_full), 0);
    check("rst_empty", 32'(o_empty), 1);
    check("rst_count", 32'(o_count), 0);
    check("rst_busy", 32'(o_busy), 0);
    check("rst_ovf", 32'(o_ovf), 0);

    // Single byte 0x55 at DIV=434.
    for (int c = 0; c <= 4345; c++) begin
      cyc = c;
      cycle(c == 0, 8'h55, 1'b0);
      if (c == 1)    check("sb_idle_tx", 32'(o_tx), 1);
      if (c == 2)    check("sb_start_first", 32'(o_tx), 0);
      if (c == 435)  check("sb_start_last", 32'(o_tx), 0);
      if (c == 436)  check("sb_bit0", 32'(o_tx), 1);
      if (c == 870)  check("sb_bit1", 32'(o_tx), 0);
      if (c == 4341) check("sb_stop_busy", 32'(o_busy), 1);
      if (c == 4342) check("sb_busy_drop", 32'(o_busy), 0);
    end

    // Back-to-back 0x00 then 0xFF: second start exactly 4340 cycles after the first.
    cyc = -1;
    cycle(1'b0, 8'h00, 1'b1);
    for (int c = 0; c <= 8690; c++) begin
      cyc = c;
      cycle(c < 2, (c == 0) ? 8'h00 : 8'hFF, 1'b0);
      if (c == 4341) check("b2b_stop", 32'(o_tx), 1);
      if (c == 4342) check("b2b_start2", 32'(o_tx), 0);
      if (c == 4776) check("b2b_ff_bit0", 32'(o_tx), 1);
      if (c == 8681) check("b2b_busy_last", 32'(o_busy), 1);
      if (c == 8682) check("b2b_busy_drop", 32'(o_busy), 0);
    end

    // Switch to the DIV=3 instance, held in reset until now.
    sel   = 1'b1;
    m_div = 3;
    model_step(1'b0, 8'h00, 1'b1);

    // Overflow: 18 bytes back to back, then a push at the stop-to-start boundary while full.
    cyc = -1;
    cycle(1'b0, 8'h00, 1'b1);
    for (int c = 0; c <= 560; c++) begin
      cyc = c;
      cycle(c < 18 || c == 31, (c == 31) ? 8'hEE : 8'(c), 1'b0);
      if (c == 16) check("ovf_not_full", 32'(o_full), 0);
      if (c == 17) check("ovf_full", 32'(o_full), 1);
      if (c == 17) check("ovf_clear", 32'(o_ovf), 0);
      if (c == 18) check("ovf_set", 32'(o_ovf), 1);
      if (c == 18) check("ovf_count16", 32'(o_count), 16);
      if (c == 31) check("pp_full", 32'(o_full), 1);
      if (c == 32) check("pp_count15", 32'(o_count), 15);
      if (c == 560) check("ovf_drained", 32'(o_busy), 0);
    end

    // Reset during data bit 3 of 0xA5 with three bytes queued.
    cyc = -1;
    cycle(1'b0, 8'h00, 1'b1);
    for (int c = 0; c <= 120; c++) begin
      cyc = c;
      cycle(c < 4, (c == 0) ? 8'hA5 : 8'(c), c == 15);
      if (c == 15) check("rm_queued", 32'(o_count), 3);
      if (c == 16) begin
        check("rm_tx", 32'(o_tx), 1);
        check("rm_empty", 32'(o_empty), 1);
        check("rm_count", 32'(o_count), 0);
        check("rm_busy", 32'(o_busy), 0);
        check("rm_ovf", 32'(o_ovf), 0);
      end
      if (c == 120) check("rm_quiet", 32'(o_tx), 1);
    end

    // Randomized traffic with varying push density and rare resets.
    cyc = -1;
    cycle(1'b0, 8'h00, 1'b1);
    for (int c = 0; c < 3000; c++) begin
      cyc = c;
      case ((c / 500) % 3)
        0:       p = 5;
        1:       p = 40;
        default: p = 90;
      endcase
      cycle($urandom_range(0, 99) < p, 8'($urandom), $urandom_range(0, 999) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Buffered 8N1 UART transmitter, the transmit counterpart of the keyboard `uart_rx` link in the po8 top level. It sends bytes back to the host over the same serial link: echoed keyboard codes, PIA/IO debug values, or CPU-written bytes through the `io` block. Producers push bytes into an internal FIFO with a single-cycle strobe. A baud-rate state machine serialises them LSB first, one start bit, one stop bit, no parity.

## Interface

Parameters:
- `CLK_FREQ`, 50_000_000: input clock frequency in Hz.
- `BAUD`, 115200: line rate in bit/s. Bit period `DIV = (CLK_FREQ + BAUD/2) / BAUD` clock cycles, so 434 at the defaults. `DIV` must be ≥ 2.
- `DEPTH`, 16: FIFO depth in bytes. Must be a power of two, ≥ 2.

Ports:
- `clk`, in, 1: system clock (50 MHz domain). One clock; reset is synchronous and active-high.
- `reset`, in, 1: synchronous, active-high reset.
- `din`, in, 8: byte to enqueue.
- `wr`, in, 1: push strobe. One byte is accepted per cycle in which `wr`=1 and `full`=0.
- `tx`, out, 1: serial line. Registered; idles high.
- `full`, out, 1: FIFO holds `DEPTH` bytes.
- `empty`, out, 1: FIFO holds 0 bytes.
- `count`, out, $clog2(DEPTH)+1: FIFO occupancy. Excludes the byte currently being shifted.
- `busy`, out, 1: `state != IDLE || !empty`.
- `overflow`, out, 1: sticky. Set when `wr`=1 while `full`=1. Cleared only by `reset`.

## Operation

- Reset values: `tx`=1, `full`=0, `empty`=1, `count`=0, `busy`=0, `overflow`=0. State is `IDLE`, FIFO pointers are 0, baud counter is 0, bit index is 0.
- FIFO push:
  - On `wr` && !`full`, `din` is written at the write pointer and the write pointer increments, wrapping modulo `DEPTH`.
  - On `wr` && `full`, the byte is dropped and `overflow` is set. A pop in the same cycle does not rescue the byte, because `full` is the registered value from the start of the cycle.
- FIFO pop: done only by the FSM when it leaves `IDLE` or `STOP` toward `START`. It latches the head byte into the shift register and increments the read pointer.
- Simultaneous push and pop: the pointers move independently and `count` is unchanged.
- A byte pushed into an empty FIFO is not visible to the FSM until the following cycle.
- FSM states: `IDLE`, `START`, `DATA`, `STOP`.
  - `IDLE`: `tx`=1. If !`empty`, pop, clear the baud counter, go to `START`.
  - `START`: `tx`=0 for `DIV` cycles, then go to `DATA` with bit index 0.
  - `DATA`: `tx`=shift[0] for `DIV` cycles, then shift right and increment the index. After bit index 7 completes, go to `STOP`.
  - `STOP`: `tx`=1 for `DIV` cycles. At the end, if !`empty`, pop and go directly to `START` (no idle gap); otherwise go to `IDLE`.
- Baud counter: counts 0..DIV-1 and wraps to 0 on each bit boundary. Width is $clog2(DIV).
- Reset mid-frame: the frame is aborted, `tx` is 1 from the next cycle, and the FIFO contents are discarded.

## Timing

- Push latency: `wr` in cycle N into an empty FIFO while `IDLE`.
  - FSM pops in cycle N+1.
  - `tx`=0 is first visible in cycle N+2.
- One frame is exactly 10×`DIV` cycles: start, 8 data bits, stop.
- Back-to-back frames: the first start-bit cycle of frame k+1 immediately follows the last stop-bit cycle of frame k.
- `full`, `empty`, `count` and `overflow` are registered and update one cycle after the causing push or pop.
- `busy` drops in the cycle after the final stop bit ends, when the FIFO is empty.

## Structure

- Shared package `uart_pkg` holds:
  - the state enumeration `uart_tx_state_t` (`IDLE`, `START`, `DATA`, `STOP`);
  - `uart_div(CLK_FREQ, BAUD)` as a constant function, so `uart_rx` can reuse the divisor.
- One sub-module, `sync_fifo` (parameters `WIDTH`, `DEPTH`; ports `clk`, `reset`, `wr`, `din`, `rd`, `dout`, `full`, `empty`, `count`). It is synchronous, has a registered read, and is reusable for a later buffered `uart_rx`.
- The top of `uart_tx` contains the FSM, baud counter, shift register and overflow flag.

## Test plan

- Single byte at defaults (`DIV`=434): pulse `wr` with `din`=8'h55 in cycle 0.
  - `tx` is low in cycles 2..435.
  - Then 1,0,1,0,1,0,1,0, each bit 434 cycles.
  - Then high for 434 cycles.
  - `busy` is 0 from cycle 4342.
- Back-to-back: push 8'h00 then 8'hFF in consecutive cycles. The second start bit begins exactly 4340 cycles after the first, with no idle cycle between frames.
- Overflow (`DEPTH`=16): push 18 bytes 0..17 in consecutive cycles from idle.
  - Byte 0 is popped in cycle 1.
  - `full`=1 after byte 16.
  - Byte 17 is dropped and `overflow`=1.
  - Transmitted sequence is 0..16.
- Simultaneous push/pop while full: at a stop-to-start boundary with `full`=1, assert `wr`. The byte is dropped, `overflow`=1, and `count` goes to 15.
- Reset mid-frame: assert `reset` for 1 cycle during bit 3 of 8'hA5 with 3 bytes queued.
  - Next cycle: `tx`=1, `empty`=1, `count`=0, `busy`=0, `overflow`=0.
  - No further start bit appears.
- Divisor rounding: `CLK_FREQ`=1_000_000, `BAUD`=300000 gives `DIV`=3. Verify that every bit lasts exactly 3 cycles.
